// File: rtl/ctrl_pkt_gen_pkg.sv
// Shared constants, types and helpers for the control-path packet generator.
// Header field offsets follow the table-write packet format consumed by the stage ALU writers.
package ctrl_pkt_pkg;

    localparam int C_S_AXIS_DATA_WIDTH  = 512;
    localparam int C_S_AXIS_TUSER_WIDTH = 128;
    localparam int ENTRY_WIDTH          = 16;
    localparam int MAX_ENTRIES          = 16;
    localparam int PTR_WIDTH            = $clog2(MAX_ENTRIES);

    localparam int          MOD_ID_OFF    = 368;
    localparam int          CTRL_FLAG_OFF = 320;
    localparam int          INDEX_OFF     = 384;
    localparam logic [15:0] CTRL_FLAG     = 16'hf2f1;

    typedef enum logic [2:0] {IDLE, LOAD, HDR, DATA, GAP} state_t;

    typedef logic [ENTRY_WIDTH-1:0] entry_t;

    typedef struct packed {
        logic [4:0] stage_id;
        logic [2:0] action_id;
        logic [3:0] index;
        logic [3:0] count;
    } req_cfg_t;

    // Packet length in bytes: one header beat plus count+1 data beats, 64 bytes each.
    function automatic logic [15:0] pkt_bytes(input logic [3:0] count);
        return ({12'd0, count} + 16'd2) << 6;
    endfunction

endpackage

// File: rtl/ctrl_pkt_gen_if.sv
// Request, entry and control-stream signals of the packet generator.
// req_flush only exists when CTRL_PKT_GEN_FLUSH_EN is defined.
interface ctrl_pkt_gen_if;
    import ctrl_pkt_pkg::*;

    logic                              req_valid;
    logic                              req_ready;
    logic [4:0]                        req_stage_id;
    logic [2:0]                        req_action_id;
    logic [3:0]                        req_index;
    logic [3:0]                        req_count;
    logic                              ent_valid;
    logic                              ent_ready;
    entry_t                            ent_data;
    logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep;
    logic                              c_m_axis_tvalid;
    logic                              c_m_axis_tlast;
    logic                              done;

`ifdef CTRL_PKT_GEN_FLUSH_EN
    logic                              req_flush;

    modport master (
        input  req_valid, req_stage_id, req_action_id, req_index, req_count,
        input  ent_valid, ent_data, req_flush,
        output req_ready, ent_ready,
        output c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tvalid, c_m_axis_tlast,
        output done
    );

    modport slave (
        output req_valid, req_stage_id, req_action_id, req_index, req_count,
        output ent_valid, ent_data, req_flush,
        input  req_ready, ent_ready,
        input  c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tvalid, c_m_axis_tlast,
        input  done
    );
`else
    modport master (
        input  req_valid, req_stage_id, req_action_id, req_index, req_count,
        input  ent_valid, ent_data,
        output req_ready, ent_ready,
        output c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tvalid, c_m_axis_tlast,
        output done
    );

    modport slave (
        output req_valid, req_stage_id, req_action_id, req_index, req_count,
        output ent_valid, ent_data,
        input  req_ready, ent_ready,
        input  c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tvalid, c_m_axis_tlast,
        input  done
    );
`endif

endinterface

// File: rtl/ctrl_pkt_gen_entry_buf.sv
// Page-table entry buffer: register file with synchronous write and asynchronous read.
module ctrl_entry_buf
    import ctrl_pkt_pkg::*;
(
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [PTR_WIDTH-1:0] wr_addr,
    input  entry_t               wr_data,
    input  logic [PTR_WIDTH-1:0] rd_addr,
    output entry_t               rd_data
);

    entry_t mem [MAX_ENTRIES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ctrl_pkt_gen.sv
// Control packet generator: buffers up to 16 entries per request, then bursts header + data beats.
// Defining CTRL_PKT_GEN_FLUSH_EN adds req_flush, which sends 16 zero entries from index 0 without LOAD.
module ctrl_pkt_gen
    import ctrl_pkt_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    ctrl_pkt_gen_if.master bus
);

    localparam int KEEP_WIDTH = C_S_AXIS_DATA_WIDTH / 8;

    state_t                          state, state_d;
    req_cfg_t                        cfg, cfg_d;
    logic [PTR_WIDTH-1:0]            wr_ptr, wr_ptr_d;
    logic [PTR_WIDTH-1:0]            rd_ptr, rd_ptr_d;
    logic                            buf_we;
    logic                            beat_hdr;
    logic                            beat_data;
    entry_t                          rd_data;
    entry_t                          beat_entry;

    logic                            req_ready_q, req_ready_d;
    logic                            ent_ready_q, ent_ready_d;
    logic                            tvalid_q, tvalid_d;
    logic                            tlast_q, tlast_d;
    logic                            done_q, done_d;
    logic [C_S_AXIS_DATA_WIDTH-1:0]  tdata_q, tdata_d;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser_q, tuser_d;
    logic [KEEP_WIDTH-1:0]           tkeep_q, tkeep_d;

    ctrl_entry_buf u_entry_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (wr_ptr),
        .wr_data (bus.ent_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

`ifdef CTRL_PKT_GEN_FLUSH_EN
    logic flush_mode, flush_d;
    assign beat_entry = flush_mode ? '0 : rd_data;
`else
    assign beat_entry = rd_data;
`endif

    // Outputs are computed for the next state and registered, so each beat appears the cycle after its transition.
    always_comb begin
        state_d   = state;
        cfg_d     = cfg;
        wr_ptr_d  = wr_ptr;
        rd_ptr_d  = rd_ptr;
        buf_we    = 1'b0;
        beat_hdr  = 1'b0;
        beat_data = 1'b0;
`ifdef CTRL_PKT_GEN_FLUSH_EN
        flush_d   = flush_mode;
`endif

        case (state)
            IDLE: begin
                if (req_ready_q) begin
`ifdef CTRL_PKT_GEN_FLUSH_EN
                    if (bus.req_flush) begin
                        cfg_d.stage_id  = bus.req_stage_id;
                        cfg_d.action_id = bus.req_action_id;
                        cfg_d.index     = '0;
                        cfg_d.count     = 4'hf;
                        flush_d         = 1'b1;
                        beat_hdr        = 1'b1;
                        state_d         = HDR;
                    end else
`endif
                    if (bus.req_valid) begin
                        cfg_d.stage_id  = bus.req_stage_id;
                        cfg_d.action_id = bus.req_action_id;
                        cfg_d.index     = bus.req_index;
                        cfg_d.count     = bus.req_count;
                        wr_ptr_d        = '0;
`ifdef CTRL_PKT_GEN_FLUSH_EN
                        flush_d         = 1'b0;
`endif
                        state_d         = LOAD;
                    end
                end
            end
            LOAD: begin
                if (bus.ent_valid && ent_ready_q) begin
                    buf_we   = 1'b1;
                    wr_ptr_d = wr_ptr + 1'b1;
                    if (wr_ptr == cfg.count) begin
                        beat_hdr = 1'b1;
                        state_d  = HDR;
                    end
                end
            end
            HDR: begin
                beat_data = 1'b1;
                state_d   = DATA;
            end
            DATA: begin
                if (tlast_q) begin
                    state_d = GAP;
                end else begin
                    beat_data = 1'b1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        tvalid_d = beat_hdr || beat_data;
        tlast_d  = 1'b0;
        tdata_d  = '0;
        if (beat_hdr) begin
            tdata_d[MOD_ID_OFF +: 8]     = {cfg_d.stage_id, cfg_d.action_id};
            tdata_d[CTRL_FLAG_OFF +: 16] = CTRL_FLAG;
            tdata_d[INDEX_OFF +: 8]      = {4'h0, cfg_d.index};
            rd_ptr_d                     = '0;
        end
        // Entries go out byte-swapped: addr_len lands in the low byte.
        if (beat_data) begin
            tdata_d[15:0] = {beat_entry[7:0], beat_entry[15:8]};
            tlast_d       = (rd_ptr == cfg.count);
            rd_ptr_d      = rd_ptr + 1'b1;
        end

        tuser_d = '0;
        if (tvalid_d) begin
            tuser_d[15:0] = pkt_bytes(cfg_d.count);
        end
        tkeep_d     = {KEEP_WIDTH{tvalid_d}};
        req_ready_d = (state_d == IDLE);
        ent_ready_d = (state_d == LOAD);
        done_d      = (state_d == GAP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cfg         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            req_ready_q <= 1'b0;
            ent_ready_q <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            done_q      <= 1'b0;
            tdata_q     <= '0;
            tuser_q     <= '0;
            tkeep_q     <= '0;
`ifdef CTRL_PKT_GEN_FLUSH_EN
            flush_mode  <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            cfg         <= cfg_d;
            wr_ptr      <= wr_ptr_d;
            rd_ptr      <= rd_ptr_d;
            req_ready_q <= req_ready_d;
            ent_ready_q <= ent_ready_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            done_q      <= done_d;
            tdata_q     <= tdata_d;
            tuser_q     <= tuser_d;
            tkeep_q     <= tkeep_d;
`ifdef CTRL_PKT_GEN_FLUSH_EN
            flush_mode  <= flush_d;
`endif
        end
    end

    assign bus.req_ready       = req_ready_q;
    assign bus.ent_ready       = ent_ready_q;
    assign bus.c_m_axis_tvalid = tvalid_q;
    assign bus.c_m_axis_tlast  = tlast_q;
    assign bus.c_m_axis_tdata  = tdata_q;
    assign bus.c_m_axis_tuser  = tuser_q;
    assign bus.c_m_axis_tkeep  = tkeep_q;
    assign bus.done            = done_q;

endmodule

// File: tb/tb_ctrl_pkt_gen.sv
// Scoreboard bench for ctrl_pkt_gen: stimulus pushes expected beats, a negedge monitor pops and compares.
// The flush scenario is exercised only when CTRL_PKT_GEN_FLUSH_EN is defined.
module tb_ctrl_pkt_gen;
    import ctrl_pkt_pkg::*;

    typedef struct {
        logic [511:0] tdata;
        logic [127:0] tuser;
        logic         tlast;
    } beat_t;

    logic   clk = 1'b0;
    logic   rst;
    beat_t  exp_q[$];
    beat_t  mon_b;
    entry_t tb_entries [16];
    int     checks = 0;
    int     errors = 0;
    logic   prev_valid = 1'b0;
    logic   prev_last  = 1'b0;

    ctrl_pkt_gen_if bus();

    ctrl_pkt_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got timeout, expected event within bound", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference packet: header then count+1 byte-swapped entry beats.
    task automatic pushExpected(input logic [4:0] stage, input logic [2:0] action,
                                input logic [3:0] index, input logic [3:0] count, input bit zero_data);
        beat_t  b;
        entry_t e;
        int     n;
        n = int'(count) + 1;
        b.tdata = '0;
        b.tdata[368 +: 8] = {stage, action};
        b.tdata[320 +: 16] = 16'hf2f1;
        b.tdata[384 +: 8] = {4'h0, index};
        b.tuser = '0;
        b.tuser[15:0] = 16'(64 * (n + 1));
        b.tlast = 1'b0;
        exp_q.push_back(b);
        for (int k = 0; k < n; k++) begin
            e = zero_data ? 16'h0000 : tb_entries[k];
            b.tdata = '0;
            b.tdata[7:0]  = e[15:8];
            b.tdata[15:8] = e[7:0];
            b.tlast = (k == n - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic waitReqReady();
        int n;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            tick();
            n++;
        end
        if (!bus.req_ready) reportTimeout("req_ready_wait");
    endtask

    task automatic issueRequest(input logic [4:0] stage, input logic [2:0] action,
                                input logic [3:0] index, input logic [3:0] count);
        waitReqReady();
        bus.req_valid     = 1'b1;
        bus.req_stage_id  = stage;
        bus.req_action_id = action;
        bus.req_index     = index;
        bus.req_count     = count;
        pushExpected(stage, action, index, count, 1'b0);
        tick();
        bus.req_valid = 1'b0;
        checkOutput("ent_ready_after_req", bus.ent_ready, 1'b1);
    endtask

    task automatic feedEntries(input logic [3:0] count, input int gap_after, input int gap_len);
        int n;
        for (int i = 0; i <= int'(count); i++) begin
            n = 0;
            bus.ent_valid = 1'b1;
            bus.ent_data  = tb_entries[i];
            while (!bus.ent_ready && n < 50) begin
                tick();
                n++;
            end
            if (!bus.ent_ready) reportTimeout("ent_ready_wait");
            tick();
            bus.ent_valid = 1'b0;
            if (i == gap_after) repeat (gap_len) tick();
        end
    endtask

    task automatic waitDone(input int expected_ticks);
        int n;
        n = 0;
        while (!bus.done && n < 100) begin
            tick();
            n++;
        end
        if (!bus.done) reportTimeout("done_wait");
        else checkOutput("done_latency", n, expected_ticks);
    endtask

    task automatic applyStimulus(input logic [4:0] stage, input logic [2:0] action, input logic [3:0] index,
                                 input logic [3:0] count, input int gap_after, input int gap_len);
        issueRequest(stage, action, index, count);
        feedEntries(count, gap_after, gap_len);
        checkOutput("hdr_after_last_entry", {bus.c_m_axis_tvalid, bus.c_m_axis_tlast, bus.ent_ready}, 3'b100);
        waitDone(int'(count) + 2);
        tick();
        checkOutput("req_ready_after_gap", {bus.req_ready, bus.done}, 2'b10);
    endtask

    // Monitor: every valid beat must match the head of the queue; bursts must not drop tvalid before tlast.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_last  = 1'b0;
        end else begin
            if (prev_valid && !prev_last) checkOutput("contiguous_tvalid", bus.c_m_axis_tvalid, 1'b1);
            if (bus.c_m_axis_tvalid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got tdata %0h, expected no beat", bus.c_m_axis_tdata);
                end else begin
                    mon_b = exp_q.pop_front();
                    checkOutput("beat_tdata", bus.c_m_axis_tdata, mon_b.tdata);
                    checkOutput("beat_tuser", bus.c_m_axis_tuser, mon_b.tuser);
                    checkOutput("beat_tkeep", bus.c_m_axis_tkeep, {64{1'b1}});
                    checkOutput("beat_tlast", bus.c_m_axis_tlast, mon_b.tlast);
                end
            end
            prev_valid = bus.c_m_axis_tvalid;
            prev_last  = bus.c_m_axis_tlast;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        bus.req_valid     = 1'b0;
        bus.req_stage_id  = '0;
        bus.req_action_id = '0;
        bus.req_index     = '0;
        bus.req_count     = '0;
        bus.ent_valid     = 1'b0;
        bus.ent_data      = '0;
`ifdef CTRL_PKT_GEN_FLUSH_EN
        bus.req_flush     = 1'b0;
`endif
        repeat (3) tick();
        checkOutput("reset_outputs", {bus.c_m_axis_tvalid, bus.c_m_axis_tlast, bus.done, bus.req_ready,
                                      bus.ent_ready, bus.c_m_axis_tkeep, bus.c_m_axis_tuser}, '0);
        checkOutput("reset_tdata", bus.c_m_axis_tdata, '0);
        rst = 1'b0;
        checkOutput("req_ready_low_at_release", bus.req_ready, 1'b0);
        tick();
        checkOutput("req_ready_rises", bus.req_ready, 1'b1);

        $display("[TB] basic packet: stage 2, action 3, index 4, N=3");
        tb_entries[0] = 16'h0A10;
        tb_entries[1] = 16'h0B20;
        tb_entries[2] = 16'h0C30;
        applyStimulus(5'd2, 3'd3, 4'd4, 4'd2, -1, 0);

        $display("[TB] full packet N=16 with entry stall after entry 5");
        for (int i = 0; i < 16; i++) tb_entries[i] = 16'(i);
        applyStimulus(5'd9, 3'd5, 4'd0, 4'd15, 5, 2);

        $display("[TB] request held during burst");
        tb_entries[0] = 16'h1234;
        tb_entries[1] = 16'h5678;
        issueRequest(5'd1, 3'd1, 4'd2, 4'd1);
        feedEntries(4'd1, -1, 0);
        tb_entries[0] = 16'hBEEF;
        bus.req_valid     = 1'b1;
        bus.req_stage_id  = 5'd17;
        bus.req_action_id = 3'd6;
        bus.req_index     = 4'd7;
        bus.req_count     = 4'd0;
        pushExpected(5'd17, 3'd6, 4'd7, 4'd0, 1'b0);
        begin
            int n;
            n = 0;
            while (!bus.req_ready && n < 100) begin
                tick();
                n++;
            end
            checkOutput("held_req_wait", n, 4);
        end
        tick();
        bus.req_valid = 1'b0;
        checkOutput("held_req_accepted", bus.ent_ready, 1'b1);
        feedEntries(4'd0, -1, 0);
        waitDone(2);
        tick();

        $display("[TB] reset during data beat 3 of 5");
        for (int i = 0; i < 5; i++) tb_entries[i] = 16'h4000 + 16'(i);
        issueRequest(5'd4, 3'd2, 4'd1, 4'd4);
        feedEntries(4'd4, -1, 0);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        checkOutput("mid_reset_outputs", {bus.c_m_axis_tvalid, bus.c_m_axis_tlast, bus.done, bus.req_ready,
                                          bus.ent_ready, bus.c_m_axis_tkeep, bus.c_m_axis_tuser}, '0);
        checkOutput("mid_reset_tdata", bus.c_m_axis_tdata, '0);
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        checkOutput("req_ready_low_after_mid_reset", bus.req_ready, 1'b0);
        tick();
        checkOutput("req_ready_after_mid_reset", bus.req_ready, 1'b1);

        $display("[TB] index 14, N=4");
        tb_entries[0] = 16'h0102;
        tb_entries[1] = 16'hA0B0;
        tb_entries[2] = 16'hFF00;
        tb_entries[3] = 16'h00FF;
        applyStimulus(5'd31, 3'd7, 4'd14, 4'd3, -1, 0);

`ifdef CTRL_PKT_GEN_FLUSH_EN
        $display("[TB] flush with simultaneous request");
        begin
            int   n;
            logic seen;
            waitReqReady();
            bus.req_flush     = 1'b1;
            bus.req_valid     = 1'b1;
            bus.req_stage_id  = 5'd7;
            bus.req_action_id = 3'd1;
            bus.req_index     = 4'd9;
            bus.req_count     = 4'd2;
            pushExpected(5'd7, 3'd1, 4'd0, 4'd15, 1'b1);
            tick();
            bus.req_flush = 1'b0;
            bus.req_valid = 1'b0;
            seen = bus.ent_ready;
            n = 0;
            while (!bus.done && n < 100) begin
                tick();
                n++;
                seen = seen | bus.ent_ready;
            end
            if (!bus.done) reportTimeout("flush_done_wait");
            else checkOutput("flush_done_latency", n, 17);
            checkOutput("flush_no_ent_ready", seen, 1'b0);
            tick();
            checkOutput("req_ready_after_flush", bus.req_ready, 1'b1);
        end
`endif

        repeat (3) tick();
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
